uart_cmd_host: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 63 ++++++
 rtl/rsp_timer.sv | 42 ++++
 rtl/uart_cmd_host.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command host: frame header bytes, command
// opcodes, FSM state encoding and per-opcode frame/response lengths.
package uart_cmd_pkg;

   // Frame header bytes (byte 0 of every frame)
   localparam logic [7:0] RF_WR_CMD   = 8'hAA;
   localparam logic [7:0] RF_RD_CMD   = 8'hBB;
   localparam logic [7:0] ALU_OP_CMD  = 8'hCC;
   localparam logic [7:0] ALU_NOP_CMD = 8'hDD;

   // cmd_op encodings
   typedef enum logic [1:0] {
      OP_RF_WR   = 2'd0,
      OP_RF_RD   = 2'd1,
      OP_ALU_OP  = 2'd2,
      OP_ALU_NOP = 2'd3
   } op_e;

   // Host FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_DONE     = 2'd3
   } state_e;

   // Frame lengths in bytes, header included
   localparam logic [2:0] FLEN_RF_WR   = 3'd3;
   localparam logic [2:0] FLEN_RF_RD   = 3'd2;
   localparam logic [2:0] FLEN_ALU_OP  = 3'd4;
   localparam logic [2:0] FLEN_ALU_NOP = 3'd2;

   // Expected response lengths in bytes
   localparam logic [1:0] RLEN_RF_WR   = 2'd0;
   localparam logic [1:0] RLEN_RF_RD   = 2'd1;
   localparam logic [1:0] RLEN_ALU_OP  = 2'd2;
   localparam logic [1:0] RLEN_ALU_NOP = 2'd2;

   // Number of bytes sent for an opcode
   function automatic logic [2:0] frame_len(input op_e op);
      logic [2:0] len;
      case (op)
         OP_RF_WR:   len = FLEN_RF_WR;
         OP_RF_RD:   len = FLEN_RF_RD;
         OP_ALU_OP:  len = FLEN_ALU_OP;
         default:    len = FLEN_ALU_NOP;
      endcase
      return len;
   endfunction

   // Number of response bytes expected for an opcode
   function automatic logic [1:0] rsp_len(input op_e op);
      logic [1:0] len;
      case (op)
         OP_RF_WR:   len = RLEN_RF_WR;
         OP_RF_RD:   len = RLEN_RF_RD;
         OP_ALU_OP:  len = RLEN_ALU_OP;
         default:    len = RLEN_ALU_NOP;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/rsp_timer.sv
// Inter-byte response timer: clears on clr, counts on inc, flags the
// terminal count TIMEOUT_CYC-1.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to zero (wins over inc)
//   inc      : advance count by one
//   term_c   : combinational, count == TIMEOUT_CYC-1
// TO_W must satisfy 2**TO_W > TIMEOUT_CYC.
module rsp_timer #(
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned TO_W        = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic term_c
);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   // Next count
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_c = (cnt_q == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_cmd_host.sv
// UART command host: serializes one command into a byte frame toward a UART
// transmitter, then collects the response bytes or flags a timeout.
//   CLK, RST              : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready only in IDLE)
//   cmd_op/addr/wdata/opa/opb/fun : command fields
//   tx_data/tx_valid/tx_ready     : frame byte stream out
//   rx_data/rx_valid      : received response bytes
//   rsp_data/rsp_valid/rsp_timeout: result, one-cycle pulse, timeout flag
//   busy                  : not IDLE
module uart_cmd_host
   import uart_cmd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned RF_ADDR     = 4,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned TO_W        = 13
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [RF_ADDR-1:0]      cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH-1:0]   cmd_opa,
   input  logic [DATA_WIDTH-1:0]   cmd_opb,
   input  logic [3:0]              cmd_fun,
   output logic [DATA_WIDTH-1:0]   tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   input  logic [DATA_WIDTH-1:0]   rx_data,
   input  logic                    rx_valid,
   output logic [2*DATA_WIDTH-1:0] rsp_data,
   output logic                    rsp_valid,
   output logic                    rsp_timeout,
   output logic                    busy
);

   localparam int unsigned RSP_W = 2 * DATA_WIDTH;

   state_e state_q, state_d;

   // Captured command fields
   op_e                    op_q,    op_d;
   logic [RF_ADDR-1:0]     addr_q,  addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  opa_q,   opa_d;
   logic [DATA_WIDTH-1:0]  opb_q,   opb_d;
   logic [3:0]             fun_q,   fun_d;

   // Byte index: frame byte while sending, response byte while waiting
   logic [1:0]             idx_q,   idx_d;

   logic [RSP_W-1:0]       rsp_data_q,    rsp_data_d;
   logic                   rsp_timeout_q, rsp_timeout_d;

   // Registered handshake/status outputs
   logic [DATA_WIDTH-1:0]  tx_data_q,   tx_data_d;
   logic                   tx_valid_q,  tx_valid_d;
   logic                   cmd_ready_q, cmd_ready_d;
   logic                   rsp_valid_q, rsp_valid_d;
   logic                   busy_q,      busy_d;

   logic accept;
   logic tx_fire;
   logic last_tx;
   logic last_rx;
   logic timer_clr;
   logic timer_inc;
   logic timer_term;

   assign accept  = cmd_valid && cmd_ready_q;
   assign tx_fire = (state_q == ST_SEND) && tx_ready;
   assign last_tx = ({1'b0, idx_q} + 3'd1) == frame_len(op_q);
   assign last_rx = (idx_q + 2'd1) == rsp_len(op_q);

   // Timer runs only while waiting; every received byte restarts it
   assign timer_clr = (state_q != ST_WAIT_RSP) || rx_valid;
   assign timer_inc = !timer_clr;

   rsp_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_rsp_timer (
      .clk    (CLK),
      .rst    (RST),
      .clr    (timer_clr),
      .inc    (timer_inc),
      .term_c (timer_term)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_fire && last_tx) begin
               state_d = (rsp_len(op_q) == 2'd0) ? ST_DONE : ST_WAIT_RSP;
            end
         end
         ST_WAIT_RSP: begin
            // A byte on the terminal cycle takes priority over the timeout
            if (rx_valid) begin
               if (last_rx) begin
                  state_d = ST_DONE;
               end
            end else if (timer_term) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Field, index and response datapath
   always_comb begin
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      opa_d         = opa_q;
      opb_d         = opb_q;
      fun_d         = fun_q;
      idx_d         = idx_q;
      rsp_data_d    = rsp_data_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d          = op_e'(cmd_op);
               addr_d        = cmd_addr;
               wdata_d       = cmd_wdata;
               opa_d         = cmd_opa;
               opb_d         = cmd_opb;
               fun_d         = cmd_fun;
               idx_d         = 2'd0;
               rsp_data_d    = '0;
               rsp_timeout_d = 1'b0;
            end
         end
         ST_SEND: begin
            if (tx_fire) begin
               if (last_tx) begin
                  idx_d      = 2'd0;
                  rsp_data_d = '0;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         ST_WAIT_RSP: begin
            if (rx_valid) begin
               // Response is assembled LSB first
               if (idx_q[0] == 1'b0) begin
                  rsp_data_d[DATA_WIDTH-1:0] = rx_data;
               end else begin
                  rsp_data_d[RSP_W-1:DATA_WIDTH] = rx_data;
               end
               idx_d = idx_q + 2'd1;
            end else if (timer_term) begin
               rsp_timeout_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Output decode from next state so every output is a flop
   always_comb begin
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      tx_valid_d  = (state_d == ST_SEND);
      rsp_valid_d = (state_d == ST_DONE);
      tx_data_d   = '0;
      if (state_d == ST_SEND) begin
         case (op_d)
            OP_RF_WR: begin
               case (idx_d)
                  2'd0:    tx_data_d = DATA_WIDTH'(RF_WR_CMD);
                  2'd1:    tx_data_d = DATA_WIDTH'(addr_d);
                  default: tx_data_d = wdata_d;
               endcase
            end
            OP_RF_RD: begin
               case (idx_d)
                  2'd0:    tx_data_d = DATA_WIDTH'(RF_RD_CMD);
                  default: tx_data_d = DATA_WIDTH'(addr_d);
               endcase
            end
            OP_ALU_OP: begin
               case (idx_d)
                  2'd0:    tx_data_d = DATA_WIDTH'(ALU_OP_CMD);
                  2'd1:    tx_data_d = opa_d;
                  2'd2:    tx_data_d = opb_d;
                  default: tx_data_d = DATA_WIDTH'(fun_d);
               endcase
            end
            default: begin
               case (idx_d)
                  2'd0:    tx_data_d = DATA_WIDTH'(ALU_NOP_CMD);
                  default: tx_data_d = DATA_WIDTH'(fun_d);
               endcase
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         op_q          <= OP_RF_WR;
         addr_q        <= '0;
         wdata_q       <= '0;
         opa_q         <= '0;
         opb_q         <= '0;
         fun_q         <= '0;
         idx_q         <= '0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         tx_data_q     <= '0;
         tx_valid_q    <= 1'b0;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         op_q          <= op_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         opa_q         <= opa_d;
         opb_q         <= opb_d;
         fun_q         <= fun_d;
         idx_q         <= idx_d;
         rsp_data_q    <= rsp_data_d;
         rsp_timeout_q <= rsp_timeout_d;
         tx_data_q     <= tx_data_d;
         tx_valid_q    <= tx_valid_d;
         cmd_ready_q   <= cmd_ready_d;
         rsp_valid_q   <= rsp_valid_d;
         busy_q        <= busy_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign busy        = busy_q;
   assign tx_data     = tx_data_q;
   assign tx_valid    = tx_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_host.sv
// Scoreboard bench for uart_cmd_host: stimulus pushes expected tx bytes and
// responses into queues, a negedge monitor pops and compares them.
module tb_uart_cmd_host;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned TO = 16;
   localparam int unsigned TW = 5;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [DW-1:0] cmd_opa = '0;
   logic [DW-1:0] cmd_opb = '0;
   logic [3:0]    cmd_fun = '0;
   logic [DW-1:0] tx_data;
   logic          tx_valid;
   logic          tx_ready = 1'b1;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic [2*DW-1:0] rsp_data;
   logic          rsp_valid;
   logic          rsp_timeout;
   logic          busy;

   always #5 CLK = ~CLK;

   uart_cmd_host #(
      .DATA_WIDTH  (DW),
      .RF_ADDR     (AW),
      .TIMEOUT_CYC (TO),
      .TO_W        (TW)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_opa     (cmd_opa),
      .cmd_opb     (cmd_opb),
      .cmd_fun     (cmd_fun),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rsp_data    (rsp_data),
      .rsp_valid   (rsp_valid),
      .rsp_timeout (rsp_timeout),
      .busy        (busy)
   );

   int nvec = 0;
   int nmis = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int rx_cyc = 0;
   int rsp_cyc = 0;
   int rsp_seen = 0;
   int tx_cyc[$];
   logic [7:0]  tx_exp[$];
   logic [16:0] rsp_exp[$];   // {timeout, data}

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bad(input string name);
      nvec++;
      nmis++;
      $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
   endtask

   // Monitor / scoreboard
   always @(negedge CLK) begin
      logic [16:0] e;
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (rx_valid) rx_cyc = cyc;
      if (tx_valid && tx_ready) begin
         tx_cyc.push_back(cyc);
         if (tx_exp.size() == 0) bad("tx_unexpected");
         else chk("tx_byte", 32'(tx_data), 32'(tx_exp.pop_front()));
      end
      if (rsp_valid) begin
         rsp_seen++;
         rsp_cyc = cyc;
         if (rsp_exp.size() == 0) bad("rsp_unexpected");
         else begin
            e = rsp_exp.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(e[15:0]));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e[16]));
            chk("done_cmd_ready", 32'(cmd_ready), 32'(0));
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      int n = 0;
      cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_opa = oa; cmd_opb = ob; cmd_fun = f;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      if (!cmd_ready) bad("cmd_ready_wait");
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic drain_tx();
      int n = 0;
      while (tx_exp.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (tx_exp.size() != 0) bad("tx_drain_wait");
   endtask

   task automatic wait_rsp(input int prev);
      int n = 0;
      while (rsp_seen == prev && n < 200) begin
         tick();
         n++;
      end
      if (rsp_seen == prev) bad("rsp_wait");
   endtask

   task automatic rx_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      int prev;
      repeat (3) tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("rst_tx_valid", 32'(tx_valid), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(0));
      chk("rst_rsp_timeout", 32'(rsp_timeout), 32'(0));
      RST = 1'b0;
      tick();

      // RF_WR addr=3 wdata=5A, back-to-back bytes
      tx_cyc.delete();
      tx_exp.push_back(8'hAA); tx_exp.push_back(8'h03); tx_exp.push_back(8'h5A);
      rsp_exp.push_back({1'b0, 16'h0000});
      prev = rsp_seen;
      issue(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0);
      wait_rsp(prev);
      chk("wr_tx_count", 32'(tx_cyc.size()), 32'(3));
      if (tx_cyc.size() == 3) begin
         chk("wr_tx0_cyc", 32'(tx_cyc[0]), 32'(acc_cyc + 1));
         chk("wr_tx1_cyc", 32'(tx_cyc[1]), 32'(acc_cyc + 2));
         chk("wr_tx2_cyc", 32'(tx_cyc[2]), 32'(acc_cyc + 3));
      end
      chk("wr_rsp_cyc", 32'(rsp_cyc), 32'(acc_cyc + 4));

      // RF_RD addr=2, stall 5 cycles on byte 1, reply 0x81
      tx_exp.push_back(8'hBB); tx_exp.push_back(8'h02);
      rsp_exp.push_back({1'b0, 16'h0081});
      prev = rsp_seen;
      issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
      tick();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_tx_data", 32'(tx_data), 32'h02);
         chk("stall_tx_valid", 32'(tx_valid), 32'(1));
         tick();
      end
      tx_ready = 1'b1;
      drain_tx();
      rx_byte(8'h81);
      wait_rsp(prev);
      repeat (3) tick();
      chk("rd_single_pulse", 32'(rsp_seen), 32'(prev + 1));

      // ALU_OP 10,20,fun0 -> replies 30,00 then 00,02
      tx_exp.push_back(8'hCC); tx_exp.push_back(8'h10); tx_exp.push_back(8'h20); tx_exp.push_back(8'h00);
      rsp_exp.push_back({1'b0, 16'h0030});
      prev = rsp_seen;
      issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0);
      drain_tx();
      rx_byte(8'h30);
      rx_byte(8'h00);
      wait_rsp(prev);

      tx_exp.push_back(8'hCC); tx_exp.push_back(8'h10); tx_exp.push_back(8'h20); tx_exp.push_back(8'h00);
      rsp_exp.push_back({1'b0, 16'h0200});
      prev = rsp_seen;
      issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h0);
      drain_tx();
      rx_byte(8'h00);
      rx_byte(8'h02);
      wait_rsp(prev);

      // Stray third byte in IDLE changes nothing
      rx_byte(8'h55);
      repeat (2) tick();
      chk("stray_rsp_data", 32'(rsp_data), 32'h0200);
      chk("stray_rsp_timeout", 32'(rsp_timeout), 32'(0));
      chk("stray_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("stray_busy", 32'(busy), 32'(0));
      chk("stray_tx_valid", 32'(tx_valid), 32'(0));
      chk("stray_no_rsp", 32'(rsp_seen), 32'(prev + 1));

      // ALU_NOP fun=4, single reply byte then timeout
      tx_exp.push_back(8'hDD); tx_exp.push_back(8'h04);
      rsp_exp.push_back({1'b1, 16'h007F});
      prev = rsp_seen;
      issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4);
      drain_tx();
      rx_byte(8'h7F);
      wait_rsp(prev);
      // Byte captured at edge rx_cyc+1; DONE is entered 16 edges later
      chk("timeout_latency", 32'(rsp_cyc - rx_cyc), 32'(17));

      // Second byte on the terminal cycle (timer == 15) wins over timeout
      tx_exp.push_back(8'hCC); tx_exp.push_back(8'h01); tx_exp.push_back(8'h02); tx_exp.push_back(8'h03);
      rsp_exp.push_back({1'b0, 16'h2211});
      prev = rsp_seen;
      issue(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3);
      drain_tx();
      rx_byte(8'h11);
      repeat (15) tick();
      chk("terminal_still_busy", 32'(busy), 32'(1));
      rx_byte(8'h22);
      wait_rsp(prev);

      // Reset while a byte is presented and stalled
      tx_ready = 1'b0;
      issue(2'd0, 4'h1, 8'h33, 8'h00, 8'h00, 4'h0);
      tick();
      chk("pre_rst_tx_valid", 32'(tx_valid), 32'(1));
      chk("pre_rst_busy", 32'(busy), 32'(1));
      RST = 1'b1;
      tick();
      chk("rst_mid_tx_valid", 32'(tx_valid), 32'(0));
      chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("rst_mid_busy", 32'(busy), 32'(0));
      RST = 1'b0;
      tx_ready = 1'b1;
      repeat (3) tick();
      chk("post_rst_tx_valid", 32'(tx_valid), 32'(0));

      // Recovery: RF_RD addr=F, reply C3
      tx_exp.push_back(8'hBB); tx_exp.push_back(8'h0F);
      rsp_exp.push_back({1'b0, 16'h00C3});
      prev = rsp_seen;
      issue(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0);
      drain_tx();
      rx_byte(8'hC3);
      wait_rsp(prev);

      repeat (3) tick();
      chk("tx_queue_empty", 32'(tx_exp.size()), 32'(0));
      chk("rsp_queue_empty", 32'(rsp_exp.size()), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
